// File: rtl/lvds_pkg.sv
// Shared definitions for the LVDS receive blocks.
// Lane-word width and alignment controller state encoding.
package lvds_pkg;

    localparam int LANE_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_SLIP,
        ST_ALIGNED,
        ST_FAIL
    } align_state_e;

endpackage

// File: rtl/lvds_sync2.sv
// Two-flop synchronizer for single-bit level signals.
// Shared by every LVDS block that samples an async status.
module lvds_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/lvds_rx_align_ctrl.sv
// Frame-clock word alignment controller for an LVDS deserializer.
// Bit-slips until the frame-clock lane shows the expected pattern.
module lvds_rx_align_ctrl
    import lvds_pkg::*;
#(
    parameter logic [LANE_W-1:0] FCLK_PATTERN = 6'b111000,
    parameter int SETTLE_CYCLES = 8,
    parameter int MATCH_CYCLES  = 16,
    parameter int MAX_SLIPS     = 12,
    parameter int LOSS_CYCLES   = 4
) (
    input  logic              rx_clk,
    input  logic              reset_n,
    input  logic              rx_locked,
    input  logic [LANE_W-1:0] fclk_word,
    input  logic              align_start,
    output logic              rx_data_align,
    output logic              aligned,
    output logic              align_err,
    output logic [3:0]        slip_count,
    output logic [7:0]        realign_count
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int MW = $clog2(MATCH_CYCLES + 1);
    localparam int LW = $clog2(LOSS_CYCLES + 1);

    align_state_e   state, state_n;
    logic [SW-1:0]  settle_cnt, settle_n;
    logic [MW-1:0]  match_cnt, match_n;
    logic [LW-1:0]  loss_cnt, loss_n;
    logic           slip_ph, ph_n;
    logic [3:0]     slips_n;
    logic [7:0]     realign_n;
    logic           locked_s;
    logic           hit;

    lvds_sync2 u_lock_sync (
        .clk   (rx_clk),
        .rst_n (reset_n),
        .d     (rx_locked),
        .q     (locked_s)
    );

    assign hit = (fclk_word == FCLK_PATTERN);

    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            settle_cnt    <= '0;
            match_cnt     <= '0;
            loss_cnt      <= '0;
            slip_ph       <= 1'b0;
            slip_count    <= '0;
            realign_count <= '0;
            rx_data_align <= 1'b0;
            aligned       <= 1'b0;
            align_err     <= 1'b0;
        end else begin
            state         <= state_n;
            settle_cnt    <= settle_n;
            match_cnt     <= match_n;
            loss_cnt      <= loss_n;
            slip_ph       <= ph_n;
            slip_count    <= slips_n;
            realign_count <= realign_n;
            rx_data_align <= (state_n == ST_SLIP);
            aligned       <= (state_n == ST_ALIGNED);
            align_err     <= (state_n == ST_FAIL);
        end
    end

    // Lock loss outranks align_start, which outranks normal flow.
    always_comb begin
        state_n   = state;
        settle_n  = settle_cnt;
        match_n   = match_cnt;
        loss_n    = loss_cnt;
        ph_n      = slip_ph;
        slips_n   = slip_count;
        realign_n = realign_count;
        if (!locked_s) begin
            state_n  = ST_IDLE;
            settle_n = '0;
            match_n  = '0;
            loss_n   = '0;
            ph_n     = 1'b0;
            slips_n  = '0;
        end else if (align_start && state != ST_IDLE) begin
            state_n  = ST_SETTLE;
            settle_n = '0;
            ph_n     = 1'b0;
            slips_n  = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state_n  = ST_SETTLE;
                    settle_n = '0;
                end
                ST_SETTLE: begin
                    if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                        state_n = ST_CHECK;
                        match_n = '0;
                    end else begin
                        settle_n = settle_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (hit) begin
                        if (match_cnt == MW'(MATCH_CYCLES - 1)) begin
                            state_n = ST_ALIGNED;
                            loss_n  = '0;
                        end else begin
                            match_n = match_cnt + 1'b1;
                        end
                    end else if (slip_count < 4'(MAX_SLIPS)) begin
                        state_n = ST_SLIP;
                        ph_n    = 1'b0;
                    end else begin
                        state_n = ST_FAIL;
                    end
                end
                ST_SLIP: begin
                    if (slip_ph) begin
                        state_n  = ST_SETTLE;
                        settle_n = '0;
                        ph_n     = 1'b0;
                        slips_n  = slip_count + 4'd1;
                    end else begin
                        ph_n = 1'b1;
                    end
                end
                ST_ALIGNED: begin
                    if (hit) begin
                        loss_n = '0;
                    end else if (loss_cnt == LW'(LOSS_CYCLES - 1)) begin
                        state_n  = ST_SETTLE;
                        settle_n = '0;
                        loss_n   = '0;
                        slips_n  = '0;
                        if (realign_count != 8'hFF)
                            realign_n = realign_count + 8'd1;
                    end else begin
                        loss_n = loss_cnt + 1'b1;
                    end
                end
                ST_FAIL: begin
                    state_n = ST_FAIL;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lvds_rx_align_ctrl.sv
// Directed bench for lvds_rx_align_ctrl.
// Slip model rotates the lane word once per rx_data_align pulse.
module tb_lvds_rx_align_ctrl;
    import lvds_pkg::*;

    localparam logic [5:0] GOOD = 6'b111000;
    localparam logic [5:0] BAD  = 6'b000111;

    logic       rx_clk = 1'b0;
    logic       reset_n;
    logic       rx_locked;
    logic       align_start;
    logic [5:0] fclk_word;
    logic [5:0] drv_word;
    logic [5:0] rot_word = BAD;
    logic       rot_en = 1'b0;
    logic       rx_data_align;
    logic       aligned;
    logic       align_err;
    logic [3:0] slip_count;
    logic [7:0] realign_count;

    int n_chk = 0;
    int n_fail = 0;
    int pulses = 0;
    int hi_cyc = 0;
    logic da_q = 1'b0;

    always #5 rx_clk = ~rx_clk;

    assign fclk_word = rot_en ? rot_word : drv_word;

    lvds_rx_align_ctrl dut (
        .rx_clk        (rx_clk),
        .reset_n       (reset_n),
        .rx_locked     (rx_locked),
        .fclk_word     (fclk_word),
        .align_start   (align_start),
        .rx_data_align (rx_data_align),
        .aligned       (aligned),
        .align_err     (align_err),
        .slip_count    (slip_count),
        .realign_count (realign_count)
    );

    // Deserializer model: each new slip pulse rotates the word by one bit.
    always @(negedge rx_clk) begin
        if (!rot_en)
            rot_word = BAD;
        if (rx_data_align) begin
            hi_cyc++;
            if (!da_q) begin
                pulses++;
                if (rot_en)
                    rot_word = {rot_word[4:0], rot_word[5]};
            end
        end
        da_q = rx_data_align;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge rx_clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        rx_locked = 1'b0;
        align_start = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
    endtask

    initial begin
        int t;
        int p0;
        int h0;
        reset_n = 1'b0;
        rx_locked = 1'b0;
        align_start = 1'b0;
        drv_word = GOOD;
        step(2);
        chk("rst_da", 32'(rx_data_align), 0);
        chk("rst_al", 32'(aligned), 0);
        chk("rst_err", 32'(align_err), 0);
        chk("rst_slip", 32'(slip_count), 0);
        chk("rst_realign", 32'(realign_count), 0);
        reset_n = 1'b1;
        step(1);

        p0 = pulses;
        rx_locked = 1'b1;
        step(24);
        chk("t1_early", 32'(aligned), 0);
        step(3);
        chk("t1_aligned", 32'(aligned), 1);
        chk("t1_pulses", 32'(pulses - p0), 0);
        chk("t1_slip", 32'(slip_count), 0);

        do_reset();
        rot_en = 1'b1;
        p0 = pulses;
        h0 = hi_cyc;
        rx_locked = 1'b1;
        t = 0;
        while (!aligned && t < 1000) begin
            step(1);
            t++;
        end
        chk("t2_aligned", 32'(aligned), 1);
        chk("t2_pulses", 32'(pulses - p0), 3);
        chk("t2_hicyc", 32'(hi_cyc - h0), 6);
        chk("t2_slip", 32'(slip_count), 3);
        rot_en = 1'b0;

        do_reset();
        drv_word = BAD;
        p0 = pulses;
        h0 = hi_cyc;
        rx_locked = 1'b1;
        t = 0;
        while (!align_err && t < 2000) begin
            step(1);
            t++;
        end
        chk("t3_err", 32'(align_err), 1);
        chk("t3_slip", 32'(slip_count), 12);
        chk("t3_pulses", 32'(pulses - p0), 12);
        chk("t3_hicyc", 32'(hi_cyc - h0), 24);
        align_start = 1'b1;
        step(1);
        align_start = 1'b0;
        chk("t3_err_clr", 32'(align_err), 0);
        chk("t3_slip_clr", 32'(slip_count), 0);
        chk("t3_settle", 32'(dut.state), 32'(ST_SETTLE));

        do_reset();
        drv_word = GOOD;
        rx_locked = 1'b1;
        t = 0;
        while (!aligned && t < 1000) begin
            step(1);
            t++;
        end
        chk("t4_aligned", 32'(aligned), 1);
        drv_word = BAD;
        step(3);
        drv_word = GOOD;
        step(1);
        chk("t4_hold", 32'(aligned), 1);
        drv_word = BAD;
        step(3);
        chk("t4_loss3", 32'(aligned), 1);
        step(1);
        chk("t4_lost", 32'(aligned), 0);
        chk("t4_realign", 32'(realign_count), 1);
        chk("t4_state", 32'(dut.state), 32'(ST_SETTLE));

        t = 0;
        while (!(rx_data_align && slip_count == 4'd1) && t < 500) begin
            step(1);
            t++;
        end
        chk("t5_in_slip", 32'(rx_data_align), 1);
        rx_locked = 1'b0;
        step(3);
        chk("t5_da", 32'(rx_data_align), 0);
        chk("t5_idle", 32'(dut.state), 32'(ST_IDLE));
        chk("t5_slip", 32'(slip_count), 0);
        chk("t5_realign", 32'(realign_count), 1);
        align_start = 1'b1;
        step(1);
        align_start = 1'b0;
        step(1);
        chk("t5_idle_start", 32'(dut.state), 32'(ST_IDLE));

        drv_word = GOOD;
        rx_locked = 1'b1;
        t = 0;
        while (dut.state != ST_CHECK && t < 200) begin
            step(1);
            t++;
        end
        chk("t6_check", 32'(dut.state), 32'(ST_CHECK));
        #2 reset_n = 1'b0;
        #1;
        chk("t6_da", 32'(rx_data_align), 0);
        chk("t6_al", 32'(aligned), 0);
        chk("t6_err", 32'(align_err), 0);
        chk("t6_slip", 32'(slip_count), 0);
        chk("t6_realign", 32'(realign_count), 0);
        chk("t6_state", 32'(dut.state), 32'(ST_IDLE));
        step(1);
        reset_n = 1'b1;
        step(1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
